parity_gen_chk: RTL and testbench
=================================

Name: parity_gen_chk

Overview:
- Parametrised parity generator/checker with one registered pipeline stage and a valid/ready handshake on both sides.
- Generate mode: appends a parity bit to a DATA_W-bit word.
- Check mode: verifies a received word plus its parity bit, flags mismatches, and keeps a saturating error count and a sticky error flag.
- Sits on datapath links between a producer and a consumer; the count and flag can be read for link-health monitoring.

Parameters:
DATA_W, 8, payload width in bits (>=1)
CNT_W, 8, error counter width in bits (>=1)

Ports:
clk        input   1         rising-edge clock, single clock domain
rst        input   1         reset, synchronous, active-high
mode       input   1         0 = generate, 1 = check; sampled on each accepted beat
odd        input   1         0 = even parity, 1 = odd parity; sampled on each accepted beat
in_valid   input   1         input beat valid
in_ready   output  1         block can accept a beat
in_data    input   DATA_W    payload
in_par     input   1         received parity bit; used only in check mode
out_valid  output  1         output beat valid
out_ready  input   1         consumer accepts the output beat
out_data   output  DATA_W+1  [DATA_W:1] = payload, [0] = parity bit
out_err    output  1         parity mismatch on the current output beat (check mode only)
err_cnt    output  CNT_W     saturating count of accepted beats with a parity mismatch
err_sticky output  1         set by any mismatch; held until cleared
clr        input   1         synchronous clear of err_cnt and err_sticky

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_err=0, err_cnt=0, err_sticky=0. in_ready=1 in the cycle after reset.
- Reset mid-operation: an in-flight output beat is dropped without being presented.
- Parity function: p = XOR-reduce(in_data) XOR odd.
  - Even parity: the total count of ones in payload plus parity bit is even.
  - Odd parity: that total is odd.
- Accept condition: a beat is accepted when in_valid && in_ready at a rising edge.
- in_ready = !out_valid || out_ready. This is combinational, giving full throughput with no bubble.
- Output transfer: the output beat completes when out_valid && out_ready.
- Latency: exactly 1 cycle. A beat accepted at edge N has out_valid=1 from edge N on, until the transfer completes.
- On accept, generate mode: out_data = {in_data, p}, out_err = 0.
- On accept, check mode: out_data = {in_data, in_par}, out_err = (in_par != p).
- Output holding: if out_valid=1 and out_ready=0, out_data and out_err hold stable. in_ready stays 0 during this time.
- Simultaneous events: a transfer and a new accept in the same cycle replace the beat, and out_valid stays 1. A transfer with no accept clears out_valid at the edge.
- Error accounting happens at acceptance, not at output transfer. An accepted check-mode beat with a mismatch:
  - increments err_cnt, which saturates at 2^CNT_W-1 and does not wrap;
  - sets err_sticky.
- clr: when high, err_cnt <= 0 and err_sticky <= 0. clr has priority over a same-cycle increment, so that error is lost. clr has no effect on the datapath.
- mode and odd may change on any cycle. Each beat uses the values present at its own acceptance edge.
- in_data and in_par are don't-care when in_valid=0.

Test Plan:
- Generate, even, DATA_W=8: in_data 0x01, then 0x03, then 0x00, out_ready=1 → out_data 0x003, 0x006, 0x000 on consecutive cycles. Each beat appears 1 cycle after acceptance. out_err=0 throughout.
- Generate, odd=1: in_data 0x00 → out_data 0x001. in_data 0xFF → out_data 0x1FF.
- Check, even: in_data 0xA5 with in_par=1 → out_data 0x14B, out_err=1, err_cnt=1, err_sticky=1. Then 0xA5 with in_par=0 → out_err=0, err_cnt stays 1.
- Backpressure: hold out_ready=0 and offer 0x10 then 0x20 → 0x10 beat held stable, in_ready=0, 0x20 not accepted. Release out_ready → 0x10 transfers, 0x20 accepted in the same cycle, no beat lost or duplicated.
- Saturation, CNT_W=2: 5 mismatching check beats → err_cnt 1,2,3,3,3. Assert clr together with a 6th mismatch → err_cnt=0, err_sticky=0.
- Reset mid-stream: assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, err_cnt=0, err_sticky=0, in_ready=1. The held beat is never presented.

Source files
------------

// File: rtl/parity_gen_chk.sv
// Parity generator / checker with one registered pipeline stage.
//
// Generate mode (mode=0) appends a parity bit to each payload word.
// Check mode (mode=1) forwards the received word plus parity bit, and flags
// a mismatch on out_err. A saturating error counter and a sticky error flag
// track mismatches for link-health monitoring.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   mode, odd       per-beat controls: check/generate, odd/even parity
//   in_valid/ready  input handshake; in_data payload, in_par received parity
//   out_valid/ready output handshake; out_data = {payload, parity}
//   out_err         mismatch flag for the presented beat (check mode only)
//   err_cnt         saturating count of accepted mismatching beats
//   err_sticky      set by any mismatch, held until clr
//   clr             synchronous clear of err_cnt and err_sticky
module parity_gen_chk #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              odd,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W:0]   out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky,
  input  logic              clr
);

  logic              valid_q, valid_d;
  logic [DATA_W:0]   data_q, data_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;

  logic accept;
  logic xfer;
  logic calc_par;
  logic mismatch;

  // Stage may be refilled in the same cycle its beat leaves: no bubble.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = valid_q && out_ready;
  assign calc_par = (^in_data) ^ odd;
  assign mismatch = mode && (in_par != calc_par);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = {in_data, (mode ? in_par : calc_par)};
      err_d   = mismatch;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  // Errors are counted at acceptance; clr wins over a same-cycle increment.
  always_comb begin
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (clr) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (accept && mismatch) begin
      sticky_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign out_err    = err_q;
  assign err_cnt    = cnt_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_parity_gen_chk.sv
// Scoreboard bench for parity_gen_chk (DATA_W=8, CNT_W=2).
// The driver pushes the hand-computed response of each accepted beat; a
// monitor on the falling edge pops and compares every completed transfer.
module tb_parity_gen_chk;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic              odd;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W:0]   out_data;
  logic              out_err;
  logic [CNT_W-1:0]  err_cnt;
  logic              err_sticky;
  logic              clr;

  int total = 0;
  int bad   = 0;

  logic [DATA_W+1:0] sb[$];  // {out_data, out_err}
  int unsigned       exp_cnt;
  logic              exp_sticky;

  parity_gen_chk #(
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .odd       (odd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_par    (in_par),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .err_sticky(err_sticky),
    .clr       (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one transfer per rising edge where out_valid && out_ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL beat: unexpected out_data=0x%0h out_err=%0b", out_data, out_err);
      end else begin
        logic [DATA_W+1:0] e;
        e = sb.pop_front();
        if ({out_data, out_err} !== e) begin
          bad++;
          $display("FAIL beat: got data=0x%0h err=%0b expected data=0x%0h err=%0b",
                   out_data, out_err, e[DATA_W+1:1], e[0]);
        end
      end
    end
  end

  // Called and returns just after a rising edge; in_valid left high.
  task automatic send(input logic [DATA_W-1:0] d, input logic p, input logic m,
                      input logic o, input logic [DATA_W:0] ed, input logic ee);
    int n = 0;
    in_data  = d;
    in_par   = p;
    mode     = m;
    odd      = o;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=0 expected 1");
    end
    sb.push_back({ed, ee});
    if (ee) begin
      exp_sticky = 1'b1;
      if (exp_cnt < 3) exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_err(input string name);
    chk({name, "_cnt"}, 32'(err_cnt), exp_cnt);
    chk({name, "_sticky"}, 32'(err_sticky), 32'(exp_sticky));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 1'b0; odd = 1'b0; in_valid = 1'b0; in_data = '0;
    in_par = 1'b0; out_ready = 1'b1; clr = 1'b0;
    exp_cnt = 0; exp_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk_err("rst");

    // Generate even, back-to-back.
    send(8'h01, 1'b0, 1'b0, 1'b0, 9'h003, 1'b0);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h003);
    send(8'h03, 1'b0, 1'b0, 1'b0, 9'h006, 1'b0);
    send(8'h00, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0);
    // Generate odd.
    send(8'h00, 1'b0, 1'b0, 1'b1, 9'h001, 1'b0);
    send(8'hFF, 1'b0, 1'b0, 1'b1, 9'h1FF, 1'b0);
    idle();
    chk("drain_valid", 32'(out_valid), 0);

    // Check even: mismatch then match.
    send(8'hA5, 1'b1, 1'b1, 1'b0, 9'h14B, 1'b1);
    chk_err("chk_bad");
    send(8'hA5, 1'b0, 1'b1, 1'b0, 9'h14A, 1'b0);
    chk_err("chk_good");
    idle();

    // Backpressure: 0x10 held, 0x20 waits.
    out_ready = 1'b0;
    send(8'h10, 1'b0, 1'b0, 1'b0, 9'h021, 1'b0);
    in_data = 8'h20;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_hold_data", 32'(out_data), 32'h021);
      chk("bp_hold_valid", 32'(out_valid), 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(8'h20, 1'b0, 1'b0, 1'b0, 9'h041, 1'b0);
    idle();
    chk("bp_sb_empty", 32'(sb.size()), 0);

    // Saturation at CNT_W=2.
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    exp_cnt = 0; exp_sticky = 1'b0;
    chk_err("clr");
    for (int i = 0; i < 5; i++) begin
      send(8'h01, 1'b0, 1'b1, 1'b0, 9'h002, 1'b1);
      chk_err("sat");
    end
    clr = 1'b1;
    send(8'h01, 1'b0, 1'b1, 1'b0, 9'h002, 1'b1);
    clr = 1'b0;
    exp_cnt = 0; exp_sticky = 1'b0;
    chk_err("clr_prio");
    idle();

    // Reset while a beat is held.
    out_ready = 1'b0;
    send(8'h01, 1'b0, 1'b1, 1'b0, 9'h002, 1'b1);
    in_valid = 1'b0;
    chk("pre_rst_cnt", 32'(err_cnt), 1);
    rst = 1'b1;
    sb.delete();
    exp_cnt = 0; exp_sticky = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk_err("midrst");
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
